vga_hvsync_gen: RTL and testbench
=================================

// Module: vga_hvsync_gen
// PURPOSE
//  Free-running VGA raster timing generator, 640x480@60 Hz by default (pixel clock 25.175 MHz; 25 MHz acceptable).
//  Produces hsync/vsync, a display-enable flag and the current pixel coordinates.
//  Top-level pixel logic (ball, text, colour mux) uses hpos/vpos/display_on to drive the RGB pins.
// PARAMETERS
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch (pixels)
//  H_SYNC     96   hsync pulse width (pixels)
//  H_BACK     48   horizontal back porch (pixels); H_TOTAL = sum of the four H parameters = 800
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BACK     33   vertical back porch (lines); V_TOTAL = sum of the four V parameters = 525
//  SYNC_POL   0    active level of hsync/vsync (0 = active-low, VESA 640x480)
// PORTS
//  clk         in   1   pixel clock; every state change on its rising edge
//  rst_n       in   1   synchronous reset, active-low
//  hsync       out  1   horizontal sync, active level = SYNC_POL
//  vsync       out  1   vertical sync, active level = SYNC_POL
//  display_on  out  1   high while (hpos, vpos) is inside the visible area
//  hpos        out  10  current pixel column, 0..H_TOTAL-1
//  vpos        out  10  current line, 0..V_TOTAL-1
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. No other reset or enable inputs.
//  - Reset (rst_n=0 at a clock edge): hpos=0, vpos=0, hsync and vsync inactive (=!SYNC_POL).
//    display_on follows the counters, so it is 1 while reset is held.
//  - Reset can occur mid-frame. The next edge forces the reset state with no partial-line artefacts.
//    The first cycle after release is pixel (0,0).
//  - hpos increments by 1 every clock. At H_TOTAL-1 (799) it wraps to 0.
//  - vpos increments only on the clock where hpos wraps 799->0. At that wrap, if vpos=V_TOTAL-1 (524), vpos wraps to 0.
//  - Simultaneous wrap (hpos=799, vpos=524) -> next cycle hpos=0, vpos=0, the start of a new frame.
//  - display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY). It is combinational from the counter registers,
//    so it has zero latency relative to hpos/vpos.
//  - hsync is active exactly on the cycles where hpos is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
//  - vsync is active exactly on the cycles where vpos is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491]
//    (all 800 pixels of both lines).
//  - hsync and vsync are registers, decoded from the next-state counter values.
//    They are glitch-free and cycle-aligned with hpos/vpos (no extra pipeline delay).
//  - Counters are 10-bit unsigned. Default totals fit, so no overflow is possible.
//    Parameters are assumed to satisfy H_TOTAL, V_TOTAL <= 1024.
//  - Frame period is 800*525 = 420000 clocks; hsync period is 800 clocks.
// STRUCTURE
//  - Single module, no sub-modules. The horizontal and vertical counters are two always blocks in this file.
//  - The 640x480 timing constants (defaults above, derived H_TOTAL/V_TOTAL, sync start/end) go in a shared
//    package vga_timing_pkg, so that pixel logic can reuse H_DISPLAY/V_DISPLAY.
// TESTING
//  - Hold rst_n=0 for 3 clocks -> hpos=0, vpos=0, hsync=vsync=1, display_on=1.
//    First cycle after release -> hpos=0; next cycle -> hpos=1.
//  - Run 800 clocks from reset -> hpos 799->0 and vpos 0->1 on the same edge.
//    display_on=0 for hpos 640..799 on line 0.
//  - hsync check -> low for exactly 96 consecutive clocks starting at hpos=656, high again at hpos=752; period 800 clocks.
//  - Run one full frame (420000 clocks) -> vsync low for exactly 1600 clocks, lines 490-491.
//    At hpos=799, vpos=524 both counters return to 0 on the next edge.
//  - Assert rst_n=0 for one clock at hpos=300, vpos=200 -> next cycle hpos=0, vpos=0, syncs inactive.
//    Timing then repeats exactly as from power-up.
//  - Sweep a whole frame -> display_on is 1 for exactly 640*480 = 307200 cycles,
//    and only when hpos<640 and vpos<480.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster timing constants, so pixel logic can reuse the
// visible-area sizes and sync windows without duplicating numbers.
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 10;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are inclusive on both ends.
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam bit SYNC_POL = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_hvsync_gen.sv
// Free-running VGA raster timing generator: pixel counters, registered syncs
// and a combinational display-enable derived from the counter registers.
module vga_hvsync_gen #(
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
    parameter bit          SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 display_on,
    output vga_timing_pkg::coord_t hpos,
    output vga_timing_pkg::coord_t vpos
);

    localparam logic [9:0] H_MAX     = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_MAX     = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS     = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS     = 10'(V_DISPLAY);
    localparam logic [9:0] H_SS      = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SE      = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SS      = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SE      = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;

    logic       w_h_wrap;
    logic [9:0] w_hpos_next;
    logic [9:0] w_vpos_next;

    assign w_h_wrap = (r_hpos == H_MAX);

    always_comb begin
        w_hpos_next = r_hpos + 10'd1;
        w_vpos_next = r_vpos;
        if (w_h_wrap) begin
            w_hpos_next = '0;
            w_vpos_next = (r_vpos == V_MAX) ? '0 : r_vpos + 10'd1;
        end
    end

    // Syncs decode the next-state counters so the registered pulse lines up
    // with the counter value it belongs to, with no extra cycle of delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hpos  <= '0;
            r_hsync <= ~SYNC_POL;
        end else begin
            r_hpos  <= w_hpos_next;
            r_hsync <= ((w_hpos_next >= H_SS) && (w_hpos_next <= H_SE)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vpos  <= '0;
            r_vsync <= ~SYNC_POL;
        end else begin
            r_vpos  <= w_vpos_next;
            r_vsync <= ((w_vpos_next >= V_SS) && (w_vpos_next <= V_SE)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign hpos       = r_hpos;
    assign vpos       = r_vpos;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign display_on = (r_hpos < H_VIS) && (r_vpos < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Self-checking bench: a default 640x480 instance for line-level timing and a
// small-raster instance (active-high syncs) for whole-frame behaviour.
module tb_vga_hvsync_gen;

    localparam int D_HD = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VD = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
    localparam int D_HT = D_HD + D_HF + D_HS + D_HB;

    localparam int S_HD = 20, S_HF = 3, S_HS = 5, S_HB = 4;
    localparam int S_VD = 12, S_VF = 2, S_VS = 3, S_VB = 4;
    localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VD + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    logic       clk = 1'b0;
    logic       rstD = 1'b0;
    logic       rstS = 1'b0;
    logic       hsD, vsD, deD, hsS, vsS, deS;
    logic [9:0] hD, vD, hS, vS;

    int tD = 0;
    int tS = 0;
    int testsRun = 0;
    int testsFailed = 0;
    int shown = 0;

    logic [9:0] eh, ev;
    logic       ehs, evs, ede;

    always #5 clk = ~clk;

    vga_hvsync_gen dutD (
        .clk(clk), .rst_n(rstD), .hsync(hsD), .vsync(vsD),
        .display_on(deD), .hpos(hD), .vpos(vD)
    );

    vga_hvsync_gen #(
        .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_POL(1'b1)
    ) dutS (
        .clk(clk), .rst_n(rstS), .hsync(hsS), .vsync(vsS),
        .display_on(deS), .hpos(hS), .vpos(vS)
    );

    // Cycles elapsed since the last clock edge that saw reset asserted.
    always @(posedge clk) begin
        tD <= (!rstD) ? 0 : tD + 1;
        tS <= (!rstS) ? 0 : tS + 1;
    end

    // Raster position is pure arithmetic on elapsed pixel clocks.
    function automatic void model(input int t, input int hd, hf, hs, hb, vd, vf, vs, vb,
                                  input bit pol, output logic [9:0] oh, ov,
                                  output logic ohs, ovs, ode);
        int ht = hd + hf + hs + hb;
        int vt = vd + vf + vs + vb;
        int h = t % ht;
        int v = (t / ht) % vt;
        oh  = 10'(h);
        ov  = 10'(v);
        ohs = (h >= hd + hf && h < hd + hf + hs) ? pol : !pol;
        ovs = (v >= vd + vf && v < vd + vf + vs) ? pol : !pol;
        ode = (h < hd) && (v < vd);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstD = 1'b0;
        rstS = 1'b0;
        repeat (3) step();
        testsRun++;
        if ({hD, vD, hsD, vsD, deD} !== {10'd0, 10'd0, 3'b111}) begin
            testsFailed++;
            $display("[TB] FAIL reset_d got h=%0d v=%0d hs=%b vs=%b de=%b want 0 0 1 1 1", hD, vD, hsD, vsD, deD);
        end
        testsRun++;
        if ({hS, vS, hsS, vsS, deS} !== {10'd0, 10'd0, 3'b001}) begin
            testsFailed++;
            $display("[TB] FAIL reset_s got h=%0d v=%0d hs=%b vs=%b de=%b want 0 0 0 0 1", hS, vS, hsS, vsS, deS);
        end
        rstD = 1'b1;
        rstS = 1'b1;
        testsRun++;
        if (hD !== 10'd0) begin
            testsFailed++;
            $display("[TB] FAIL release_first got hpos=%0d want 0", hD);
        end
        step();
        testsRun++;
        if (hD !== 10'd1 || hS !== 10'd1) begin
            testsFailed++;
            $display("[TB] FAIL release_second got hpos_d=%0d hpos_s=%0d want 1", hD, hS);
        end
    endtask

    task automatic test_first_line();
        int deCount = 0;
        rstD = 1'b0;
        step();
        rstD = 1'b1;
        for (int i = 0; i <= D_HT + 5; i++) begin
            if (i > 0) step();
            model(tD, D_HD, D_HF, D_HS, D_HB, D_VD, D_VF, D_VS, D_VB, 1'b0, eh, ev, ehs, evs, ede);
            testsRun++;
            if ({hD, vD, hsD, vsD, deD} !== {eh, ev, ehs, evs, ede}) begin
                testsFailed++;
                if (shown++ < 20)
                    $display("[TB] FAIL line_d t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b want h=%0d v=%0d hs=%b vs=%b de=%b",
                             tD, hD, vD, hsD, vsD, deD, eh, ev, ehs, evs, ede);
            end
            if (tD < D_HT && deD === 1'b1) deCount++;
            if (tD == D_HT - 1) begin
                testsRun++;
                if (hD !== 10'd799 || vD !== 10'd0) begin
                    testsFailed++;
                    $display("[TB] FAIL line_end got h=%0d v=%0d want 799 0", hD, vD);
                end
            end
            if (tD == D_HT) begin
                testsRun++;
                if (hD !== 10'd0 || vD !== 10'd1) begin
                    testsFailed++;
                    $display("[TB] FAIL line_wrap got h=%0d v=%0d want 0 1", hD, vD);
                end
            end
        end
        testsRun++;
        if (deCount != D_HD) begin
            testsFailed++;
            $display("[TB] FAIL line_de_count got %0d want %0d", deCount, D_HD);
        end
    endtask

    task automatic test_hsync();
        int fallT[$];
        int fallH[$];
        int riseH[$];
        int lowLen[$];
        int run = 0;
        logic prev;
        rstD = 1'b0;
        step();
        rstD = 1'b1;
        prev = hsD;
        for (int i = 0; i < 2 * D_HT + 100; i++) begin
            step();
            if (prev && !hsD) begin
                fallT.push_back(tD);
                fallH.push_back(int'(hD));
                run = 0;
            end
            if (!hsD) run++;
            if (!prev && hsD) begin
                riseH.push_back(int'(hD));
                lowLen.push_back(run);
            end
            prev = hsD;
        end
        testsRun++;
        if (fallT.size() < 2 || riseH.size() < 1) begin
            testsFailed++;
            $display("[TB] FAIL hsync_edges got falls=%0d rises=%0d want >=2 >=1", fallT.size(), riseH.size());
        end else begin
            testsRun++;
            if (fallH[0] != D_HD + D_HF) begin
                testsFailed++;
                $display("[TB] FAIL hsync_start got hpos=%0d want %0d", fallH[0], D_HD + D_HF);
            end
            testsRun++;
            if (lowLen[0] != D_HS) begin
                testsFailed++;
                $display("[TB] FAIL hsync_width got %0d want %0d", lowLen[0], D_HS);
            end
            testsRun++;
            if (riseH[0] != D_HD + D_HF + D_HS) begin
                testsFailed++;
                $display("[TB] FAIL hsync_end got hpos=%0d want %0d", riseH[0], D_HD + D_HF + D_HS);
            end
            testsRun++;
            if (fallT[1] - fallT[0] != D_HT) begin
                testsFailed++;
                $display("[TB] FAIL hsync_period got %0d want %0d", fallT[1] - fallT[0], D_HT);
            end
        end
    endtask

    task automatic test_frame();
        int vsCount = 0;
        int deCount = 0;
        int wraps = 0;
        logic [9:0] ph = '0, pv = '0;
        rstS = 1'b0;
        step();
        rstS = 1'b1;
        for (int i = 0; i <= S_FRAME + 5; i++) begin
            if (i > 0) step();
            model(tS, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b1, eh, ev, ehs, evs, ede);
            testsRun++;
            if ({hS, vS, hsS, vsS, deS} !== {eh, ev, ehs, evs, ede}) begin
                testsFailed++;
                if (shown++ < 20)
                    $display("[TB] FAIL frame_s t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b want h=%0d v=%0d hs=%b vs=%b de=%b",
                             tS, hS, vS, hsS, vsS, deS, eh, ev, ehs, evs, ede);
            end
            if (tS < S_FRAME) begin
                if (vsS === 1'b1) vsCount++;
                if (deS === 1'b1) deCount++;
            end
            if (i > 0 && ph == 10'(S_HT - 1) && pv == 10'(S_VT - 1)) begin
                wraps++;
                testsRun++;
                if (hS !== 10'd0 || vS !== 10'd0) begin
                    testsFailed++;
                    $display("[TB] FAIL frame_wrap got h=%0d v=%0d want 0 0", hS, vS);
                end
            end
            ph = hS;
            pv = vS;
        end
        testsRun++;
        if (wraps != 1) begin
            testsFailed++;
            $display("[TB] FAIL frame_wrap_seen got %0d want 1", wraps);
        end
        testsRun++;
        if (vsCount != S_HT * S_VS) begin
            testsFailed++;
            $display("[TB] FAIL vsync_cycles got %0d want %0d", vsCount, S_HT * S_VS);
        end
        testsRun++;
        if (deCount != S_HD * S_VD) begin
            testsFailed++;
            $display("[TB] FAIL de_cycles got %0d want %0d", deCount, S_HD * S_VD);
        end
    endtask

    task automatic test_midframe_reset();
        rstD = 1'b0;
        step();
        rstD = 1'b1;
        repeat (D_HT + 300) step();
        testsRun++;
        if (hD !== 10'd300 || vD !== 10'd1) begin
            testsFailed++;
            $display("[TB] FAIL mid_pos got h=%0d v=%0d want 300 1", hD, vD);
        end
        rstD = 1'b0;
        step();
        rstD = 1'b1;
        testsRun++;
        if ({hD, vD, hsD, vsD} !== {10'd0, 10'd0, 2'b11}) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset got h=%0d v=%0d hs=%b vs=%b want 0 0 1 1", hD, vD, hsD, vsD);
        end
        for (int i = 0; i < D_HT + 100; i++) begin
            step();
            model(tD, D_HD, D_HF, D_HS, D_HB, D_VD, D_VF, D_VS, D_VB, 1'b0, eh, ev, ehs, evs, ede);
            testsRun++;
            if ({hD, vD, hsD, vsD, deD} !== {eh, ev, ehs, evs, ede}) begin
                testsFailed++;
                if (shown++ < 20)
                    $display("[TB] FAIL mid_resume t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b want h=%0d v=%0d hs=%b vs=%b de=%b",
                             tD, hD, vD, hsD, vsD, deD, eh, ev, ehs, evs, ede);
            end
        end
    endtask

    // Random run lengths with random reset pulses on either instance.
    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int runLen = int'($urandom_range(40, 700));
            for (int c = 0; c < runLen; c++) begin
                step();
                model(tD, D_HD, D_HF, D_HS, D_HB, D_VD, D_VF, D_VS, D_VB, 1'b0, eh, ev, ehs, evs, ede);
                testsRun++;
                if ({hD, vD, hsD, vsD, deD} !== {eh, ev, ehs, evs, ede}) begin
                    testsFailed++;
                    if (shown++ < 20)
                        $display("[TB] FAIL rand_d t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b want h=%0d v=%0d",
                                 tD, hD, vD, hsD, vsD, deD, eh, ev);
                end
                model(tS, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b1, eh, ev, ehs, evs, ede);
                testsRun++;
                if ({hS, vS, hsS, vsS, deS} !== {eh, ev, ehs, evs, ede}) begin
                    testsFailed++;
                    if (shown++ < 20)
                        $display("[TB] FAIL rand_s t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b want h=%0d v=%0d",
                                 tS, hS, vS, hsS, vsS, deS, eh, ev);
                end
                rstD = 1'b1;
                rstS = 1'b1;
            end
            case ($urandom_range(0, 2))
                0: rstD = 1'b0;
                1: rstS = 1'b0;
                default: begin
                    rstD = 1'b0;
                    rstS = 1'b0;
                end
            endcase
        end
        rstD = 1'b1;
        rstS = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_line();
        test_hsync();
        test_frame();
        test_midframe_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
